menu_stats_ctrl: RTL and testbench

- Sequential control and statistics engine behind the menu screen.
- Runs the mode/value selection FSM from debounced key pulses and issues the game-start pulse.
- Keeps a ring buffer of the last DEPTH game results (WPM, accuracy) and maintains all-time best values plus windowed averages, computed with a multi-cycle divider.
- Its outputs feed the menu renderer's mode, value, wpm_best, wpm_average, acc_best and acc_average inputs.

---
 rtl/typeracer_pkg.sv | 12 +
 rtl/menu_stats_ctrl_divider.sv | 43 ++++
 rtl/menu_stats_ctrl.sv | 141 ++++++++++++++
 tb/tb_menu_stats_ctrl.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/typeracer_pkg.sv
// typeracer_pkg: shared FSM state type, mode encodings and menu value range defaults.
package typeracer_pkg;
  typedef enum logic [1:0] {IDLE, UPDATE, DIV_WPM, DIV_ACC} state_t;
  localparam logic MODE_TIME = 1'b0;
  localparam logic MODE_WORD = 1'b1;
  localparam int TIME_MIN_DEF = 15;
  localparam int TIME_MAX_DEF = 60;
  localparam int TIME_STEP_DEF = 15;
  localparam int WORD_MIN_DEF = 10;
  localparam int WORD_MAX_DEF = 50;
  localparam int WORD_STEP_DEF = 10;
endpackage

// File: rtl/menu_stats_ctrl_divider.sv
// seq_divider: unsigned restoring divider, one quotient bit per cycle; the start cycle performs the first step.
module seq_divider #(
  parameter int W = 13
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic         done,
  output logic         run
);
  localparam int CW = $clog2(W);
  logic [W-1:0] rem, quo, r0, q0, rem_next, quo_next;
  logic [CW-1:0] cnt, c0;
  logic [W:0] shifted;
  logic fit;
  always_comb begin
    r0 = start ? '0 : rem;
    q0 = start ? dividend : quo;
    c0 = start ? '0 : cnt;
    shifted = {r0, q0[W-1]};
    fit = shifted >= {1'b0, divisor};
    rem_next = fit ? shifted[W-1:0] - divisor : shifted[W-1:0];
    quo_next = {q0[W-2:0], fit};
    done = (start || run) && c0 == CW'(W - 1);
    quotient = quo_next;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem <= '0;
      quo <= '0;
      cnt <= '0;
      run <= 1'b0;
    end else if (start || run) begin
      rem <= rem_next;
      quo <= quo_next;
      cnt <= c0 + CW'(1);
      run <= !done;
    end
  end
endmodule

// File: rtl/menu_stats_ctrl.sv
// menu_stats_ctrl: menu mode/value selection, game start pulse, and result history with best/average stats.
// MENU_WRAP_EN: when defined, up at MAX wraps to MIN and down at MIN wraps to MAX.
module menu_stats_ctrl
  import typeracer_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WPM_W = 10,
  parameter int ACC_W = 7,
  parameter int VAL_W = 7,
  parameter int TIME_MIN = TIME_MIN_DEF,
  parameter int TIME_MAX = TIME_MAX_DEF,
  parameter int TIME_STEP = TIME_STEP_DEF,
  parameter int WORD_MIN = WORD_MIN_DEF,
  parameter int WORD_MAX = WORD_MAX_DEF,
  parameter int WORD_STEP = WORD_STEP_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     key_up,
  input  logic                     key_down,
  input  logic                     key_left,
  input  logic                     key_right,
  input  logic                     key_enter,
  input  logic                     game_done,
  input  logic [WPM_W-1:0]         wpm_in,
  input  logic [ACC_W-1:0]         acc_in,
  output logic                     mode,
  output logic [VAL_W-1:0]         value,
  output logic                     start,
  output logic                     busy,
  output logic [WPM_W-1:0]         wpm_best,
  output logic [ACC_W-1:0]         acc_best,
  output logic [WPM_W-1:0]         wpm_average,
  output logic [ACC_W-1:0]         acc_average,
  output logic [$clog2(DEPTH):0]   games
);
  localparam int LG = $clog2(DEPTH);
  localparam int GW = LG + 1;
  localparam int SUM_W = WPM_W + LG;
  localparam int ASUM_W = ACC_W + LG;
  state_t state, state_next;
  logic [WPM_W-1:0] wpm_buf [DEPTH];
  logic [ACC_W-1:0] acc_buf [DEPTH];
  logic [WPM_W-1:0] wpm_lat;
  logic [ACC_W-1:0] acc_lat;
  logic [LG-1:0] wr_ptr;
  logic [SUM_W-1:0] wpm_sum, div_q;
  logic [ASUM_W-1:0] acc_sum;
  logic full, keys_ok, toggle, mode_next, div_start, div_done, div_run;
  logic [VAL_W-1:0] mn, mx, st, wrap_up, wrap_dn, up_val, dn_val, value_next;
  assign busy = state != IDLE;
  assign full = games == GW'(DEPTH);
  always_comb begin
    state_next = state == IDLE ? (game_done ? UPDATE : IDLE)
               : state == UPDATE ? DIV_WPM
               : div_done ? (state == DIV_WPM ? DIV_ACC : IDLE) : state;
    div_start = (state == DIV_WPM || state == DIV_ACC) && !div_run;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_next;
  end
  always_comb begin
    mn = VAL_W'(mode ? WORD_MIN : TIME_MIN);
    mx = VAL_W'(mode ? WORD_MAX : TIME_MAX);
    st = VAL_W'(mode ? WORD_STEP : TIME_STEP);
`ifdef MENU_WRAP_EN
    wrap_up = mn;
    wrap_dn = mx;
`else
    wrap_up = value;
    wrap_dn = value;
`endif
    up_val = value >= mx ? wrap_up : value + st;
    dn_val = value <= mn ? wrap_dn : value - st;
    keys_ok = state == IDLE && !game_done;
    toggle = key_left || key_right;
    mode_next = keys_ok && !key_enter && toggle ? ~mode : mode;
    value_next = !keys_ok || key_enter ? value
               : toggle ? VAL_W'(mode ? TIME_MIN : WORD_MIN)
               : key_up ? up_val
               : key_down ? dn_val : value;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode <= MODE_TIME;
      value <= VAL_W'(TIME_MIN);
      start <= 1'b0;
    end else begin
      mode <= mode_next;
      value <= value_next;
      start <= keys_ok && key_enter;
    end
  end
  // Results are latched with game_done since the inputs need not stay valid into UPDATE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wpm_lat <= '0;
      acc_lat <= '0;
      wr_ptr <= '0;
      wpm_sum <= '0;
      acc_sum <= '0;
      games <= '0;
      wpm_best <= '0;
      acc_best <= '0;
      wpm_average <= '0;
      acc_average <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        wpm_buf[i] <= '0;
        acc_buf[i] <= '0;
      end
    end else begin
      if (state == IDLE && game_done) begin
        wpm_lat <= wpm_in;
        acc_lat <= acc_in;
      end
      if (state == UPDATE) begin
        wpm_buf[wr_ptr] <= wpm_lat;
        acc_buf[wr_ptr] <= acc_lat;
        wr_ptr <= wr_ptr + LG'(1);
        wpm_sum <= wpm_sum - (full ? SUM_W'(wpm_buf[wr_ptr]) : '0) + SUM_W'(wpm_lat);
        acc_sum <= acc_sum - (full ? ASUM_W'(acc_buf[wr_ptr]) : '0) + ASUM_W'(acc_lat);
        games <= full ? games : games + GW'(1);
        wpm_best <= wpm_lat > wpm_best ? wpm_lat : wpm_best;
        acc_best <= acc_lat > acc_best ? acc_lat : acc_best;
      end
      if (div_done && state == DIV_WPM) wpm_average <= WPM_W'(div_q);
      if (div_done && state == DIV_ACC) acc_average <= ACC_W'(div_q);
    end
  end
  seq_divider #(.W(SUM_W)) u_div (
    .clk(clk),
    .rst(rst),
    .start(div_start),
    .dividend(state == DIV_ACC ? SUM_W'(acc_sum) : wpm_sum),
    .divisor(SUM_W'(games)),
    .quotient(div_q),
    .done(div_done),
    .run(div_run)
  );
endmodule

// File: tb/tb_menu_stats_ctrl.sv
// tb_menu_stats_ctrl: scoreboard bench for menu keys, start pulse, game statistics and mid-division reset.
module tb_menu_stats_ctrl;
  localparam int LAT = 1 + 2 * 13;
  logic clk = 0, rst = 1;
  logic key_up = 0, key_down = 0, key_left = 0, key_right = 0, key_enter = 0, game_done = 0;
  logic [9:0] wpm_in = '0;
  logic [6:0] acc_in = '0;
  logic mode, start, busy;
  logic [6:0] value, acc_best, acc_average;
  logic [9:0] wpm_best, wpm_average;
  logic [3:0] games;
  typedef struct { int wb; int ab; int wa; int aa; int g; } exp_t;
  exp_t sb[$];
  int hw[$], ha[$];
  int best_w = 0, best_a = 0, prev_aa = 0;
  int n_checks = 0, n_fail = 0;

  menu_stats_ctrl dut (
    .clk(clk), .rst(rst), .key_up(key_up), .key_down(key_down), .key_left(key_left),
    .key_right(key_right), .key_enter(key_enter), .game_done(game_done), .wpm_in(wpm_in),
    .acc_in(acc_in), .mode(mode), .value(value), .start(start), .busy(busy),
    .wpm_best(wpm_best), .acc_best(acc_best), .wpm_average(wpm_average),
    .acc_average(acc_average), .games(games)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset();
    check("rst_mode", 32'(mode), 0);
    check("rst_value", 32'(value), 15);
    check("rst_start", 32'(start), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_wpm_best", 32'(wpm_best), 0);
    check("rst_acc_best", 32'(acc_best), 0);
    check("rst_wpm_avg", 32'(wpm_average), 0);
    check("rst_acc_avg", 32'(acc_average), 0);
    check("rst_games", 32'(games), 0);
  endtask

  task automatic press(input logic u, input logic d, input logic l, input logic r, input logic e);
    @(negedge clk);
    key_up = u; key_down = d; key_left = l; key_right = r; key_enter = e;
    @(negedge clk);
    key_up = 0; key_down = 0; key_left = 0; key_right = 0; key_enter = 0;
  endtask

  task automatic run_game(input int w, input int a, input bit enter_too, input bit poke);
    exp_t e;
    int sw = 0, sa = 0, cyc;
    hw.push_back(w);
    ha.push_back(a);
    if (hw.size() > 8) begin
      void'(hw.pop_front());
      void'(ha.pop_front());
    end
    foreach (hw[i]) begin
      sw += hw[i];
      sa += ha[i];
    end
    if (w > best_w) best_w = w;
    if (a > best_a) best_a = a;
    sb.push_back('{best_w, best_a, sw / hw.size(), sa / ha.size(), hw.size()});
    @(negedge clk);
    game_done = 1; wpm_in = 10'(w); acc_in = 7'(a); key_enter = enter_too;
    @(negedge clk);
    game_done = 0; wpm_in = '0; acc_in = '0; key_enter = 0;
    cyc = 0;
    if (enter_too) check("done_beats_enter", 32'(start), 0);
    while (busy && cyc < 200) begin
      if (poke && cyc == 5) begin
        key_enter = 1;
        key_up = 1;
      end
      @(negedge clk);
      cyc++;
      key_enter = 0;
      key_up = 0;
      if (poke && cyc == 6) begin
        check("busy_no_start", 32'(start), 0);
        check("busy_value_held", 32'(value), 15);
      end
      if (cyc == 20) begin
        check("mid_wpm_avg_new", 32'(wpm_average), 32'(sb[0].wa));
        check("mid_acc_avg_old", 32'(acc_average), 32'(prev_aa));
      end
    end
    check("latency", 32'(cyc), 32'(LAT));
    e = sb.pop_front();
    check("wpm_best", 32'(wpm_best), 32'(e.wb));
    check("acc_best", 32'(acc_best), 32'(e.ab));
    check("wpm_avg", 32'(wpm_average), 32'(e.wa));
    check("acc_avg", 32'(acc_average), 32'(e.aa));
    check("games", 32'(games), 32'(e.g));
    prev_aa = e.aa;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset();
    rst = 0;
    press(1, 0, 0, 0, 0); check("up1", 32'(value), 30);
    press(1, 0, 0, 0, 0); check("up2", 32'(value), 45);
    press(1, 0, 0, 0, 0); check("up3", 32'(value), 60);
    press(1, 0, 0, 0, 0);
`ifdef MENU_WRAP_EN
    check("up4_wrap", 32'(value), 15);
    press(1, 0, 0, 0, 0);
    press(1, 0, 0, 0, 0);
`else
    check("up4_sat", 32'(value), 60);
    press(0, 1, 0, 0, 0);
`endif
    check("value45", 32'(value), 45);
    press(0, 0, 0, 1, 0);
    check("right_mode", 32'(mode), 1);
    check("right_value", 32'(value), 10);
    press(0, 1, 0, 0, 0);
`ifdef MENU_WRAP_EN
    check("word_down_wrap", 32'(value), 50);
`else
    check("word_down_sat", 32'(value), 10);
`endif
    press(0, 0, 1, 0, 0);
    check("left_mode", 32'(mode), 0);
    check("left_value", 32'(value), 15);
    press(1, 0, 1, 0, 0);
    check("left_beats_up_mode", 32'(mode), 1);
    check("left_beats_up_value", 32'(value), 10);
    press(1, 0, 0, 0, 0); check("word_up", 32'(value), 20);
    press(0, 0, 0, 1, 0); check("back_to_time", 32'(value), 15);
    press(1, 0, 0, 0, 1);
    check("enter_start", 32'(start), 1);
    check("enter_beats_up", 32'(value), 15);
    @(negedge clk);
    check("start_one_cycle", 32'(start), 0);
    run_game(40, 90, 1, 0);
    run_game(60, 80, 0, 0);
    @(negedge clk);
    game_done = 1; wpm_in = 10'd55; acc_in = 7'd44;
    @(negedge clk);
    game_done = 0;
    repeat (4) @(negedge clk);
    check("busy_before_rst", 32'(busy), 1);
    rst = 1;
    #1;
    check_reset();
    hw.delete(); ha.delete();
    best_w = 0; best_a = 0; prev_aa = 0;
    @(negedge clk);
    rst = 0;
    run_game(77, 66, 0, 0);
    for (int i = 1; i <= 10; i++) run_game(i * 10, 50, 0, i == 1);
    check("ten_games_n", 32'(games), 8);
    check("ten_games_avg", 32'(wpm_average), 65);
    check("ten_games_best", 32'(wpm_best), 100);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
